// File: rtl/vid_capture_ctrl.sv
// Frame-capture sequencer: aligns PS start/stop/frame-count commands to vsync
// boundaries, gates the downstream writer and checks each frame's geometry.
module vid_capture_ctrl #(
    parameter int CAM_IMAGE_WIDTH  = 1280,
    parameter int CAM_IMAGE_HEIGHT = 720
) (
    input  logic        PixelClk,
    input  logic        vid_rstn,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [15:0] cmd_nframes,
    input  logic        vid_in_vsync,
    input  logic        vid_in_VDE,
    output logic        cap_en,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        CAPTURE  = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam logic [11:0] EXP_W   = 12'(CAM_IMAGE_WIDTH);
    localparam logic [11:0] EXP_H   = 12'(CAM_IMAGE_HEIGHT);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t      state, state_d;
    logic        vs_q, vde_q;
    logic        vs_rise, vde_fall;
    logic [15:0] nframes;
    logic [15:0] frames_done;
    logic [15:0] frames_inc;
    logic [11:0] last_lines;
    logic [11:0] pix_cnt, line_cnt;
    logic        err;
    logic        active;
    logic        last_frame;

    logic        accept_start;
    logic        frame_begin;
    logic        frame_end;
    logic        frame_start_d;
    logic        frame_done_d;

    assign vs_rise    = vid_in_vsync & ~vs_q;
    assign vde_fall   = vde_q & ~vid_in_VDE;
    assign active     = (state == CAPTURE) || (state == STOPPING);
    assign frames_inc = frames_done + 16'd1;
    assign last_frame = (nframes != 16'd0) && (frames_inc == nframes);

    always_ff @(posedge PixelClk) begin
        if (!vid_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d       = state;
        accept_start  = 1'b0;
        frame_begin   = 1'b0;
        frame_end     = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    state_d      = ARM;
                    accept_start = 1'b1;
                end
            end
            ARM: begin
                // A stop while armed wins over a coincident vsync: nothing is captured.
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d       = CAPTURE;
                    frame_begin   = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    frame_end    = 1'b1;
                    frame_done_d = 1'b1;
                    if (last_frame || cmd_stop) begin
                        state_d = IDLE;
                    end else begin
                        frame_begin   = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end else if (cmd_stop) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (vs_rise) begin
                    frame_end    = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PixelClk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        if (!vid_rstn) begin
            vs_q        <= 1'b0;
            vde_q       <= 1'b0;
            cap_en      <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            nframes     <= 16'd0;
            frames_done <= 16'd0;
            last_lines  <= 12'd0;
            pix_cnt     <= 12'd0;
            line_cnt    <= 12'd0;
            err         <= 1'b0;
        end else begin
            vs_q        <= vid_in_vsync;
            vde_q       <= vid_in_VDE;
            cap_en      <= vid_in_VDE & active;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;

            if (accept_start) begin
                nframes     <= cmd_nframes;
                frames_done <= 16'd0;
            end else if (frame_end) begin
                frames_done <= frames_inc;
                last_lines  <= line_cnt;
            end

            if (frame_begin) begin
                pix_cnt <= 12'd0;
            end else if (active) begin
                if (vde_fall) begin
                    pix_cnt <= 12'd0;
                end else if (vid_in_VDE && pix_cnt != CNT_MAX) begin
                    pix_cnt <= pix_cnt + 12'd1;
                end
            end

            if (frame_begin) begin
                line_cnt <= 12'd0;
            end else if (active && vde_fall && line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + 12'd1;
            end

            // err is sticky: only an accepted start clears it.
            if (accept_start) begin
                err <= 1'b0;
            end else begin
                err <= err
                     | (active && vde_fall && pix_cnt != EXP_W)
                     | (frame_end && line_cnt != EXP_H);
            end
        end
    end

    assign busy   = (state != IDLE);
    assign status = {err, busy, state, last_lines, frames_done};

endmodule

// File: tb/tb_vid_capture_ctrl.sv
// Directed bench for vid_capture_ctrl with a tiny 8x4 frame geometry.
module tb_vid_capture_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        vid_rstn;
    logic        cmd_start;
    logic        cmd_stop;
    logic [15:0] cmd_nframes;
    logic        vid_in_vsync;
    logic        vid_in_VDE;
    logic        cap_en;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic [31:0] status;

    int vectors     = 0;
    int miscompares = 0;
    int fs_cnt = 0, fd_cnt = 0, ce_cnt = 0;
    int fs0, fd0, ce0;

    vid_capture_ctrl #(.CAM_IMAGE_WIDTH(W), .CAM_IMAGE_HEIGHT(H)) dut (
        .PixelClk    (clk),
        .vid_rstn    (vid_rstn),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cmd_nframes (cmd_nframes),
        .vid_in_vsync(vid_in_vsync),
        .vid_in_VDE  (vid_in_VDE),
        .cap_en      (cap_en),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .status      (status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
        if (cap_en)      ce_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        ce0 = ce_cnt;
    endtask

    task automatic start(input logic [15:0] nf);
        cmd_start   = 1'b1;
        cmd_nframes = nf;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic vsync();
        vid_in_vsync = 1'b1;
        tick();
        vid_in_vsync = 1'b0;
    endtask

    task automatic line(input int npix);
        vid_in_VDE = 1'b1;
        tick(npix);
        vid_in_VDE = 1'b0;
        tick(3);
    endtask

    task automatic frame();
        for (int i = 0; i < H; i++) line(W);
        tick(2);
    endtask

    initial begin
        vid_rstn     = 1'b0;
        cmd_start    = 1'b0;
        cmd_stop     = 1'b0;
        cmd_nframes  = 16'd0;
        vid_in_vsync = 1'b0;
        vid_in_VDE   = 1'b0;
        tick(3);
        check("reset_status", status, 32'h0);
        check("reset_cap_en", 32'(cap_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        vid_rstn = 1'b1;
        tick(2);

        // Single frame
        snap();
        start(16'd1);
        check("single_armed", status, 32'h5000_0000);
        vsync();
        check("single_fstart", 32'(frame_start), 32'd1);
        check("single_capture_state", 32'(status[29:28]), 32'd2);
        frame();
        vsync();
        check("single_fdone", 32'(frame_done), 32'd1);
        check("single_status", status, 32'h0004_0001);
        tick(3);
        check("single_fs_count", 32'(fs_cnt - fs0), 32'd1);
        check("single_fd_count", 32'(fd_cnt - fd0), 32'd1);
        check("single_cap_en_count", 32'(ce_cnt - ce0), 32'd32);
        check("single_busy", 32'(busy), 32'd0);

        // Continuous run, stop in the middle of frame 4
        snap();
        start(16'd0);
        vsync();
        for (int f = 0; f < 3; f++) begin
            frame();
            vsync();
        end
        check("cont_three_done", 32'(status[15:0]), 32'd3);
        line(W);
        line(W);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("cont_stopping", 32'(status[29:28]), 32'd3);
        line(W);
        line(W);
        tick(2);
        vsync();
        check("cont_final_status", status, 32'h0004_0004);
        tick(3);
        check("cont_fd_count", 32'(fd_cnt - fd0), 32'd4);
        check("cont_cap_en_count", 32'(ce_cnt - ce0), 32'd128);

        // Geometry error: line 1 of frame 1 is one pixel short
        start(16'd2);
        vsync();
        line(W);
        line(W - 1);
        check("geom_err_set", 32'(status[31]), 32'd1);
        line(W);
        line(W);
        tick(2);
        vsync();
        check("geom_still_running", 32'(status[29:28]), 32'd2);
        frame();
        vsync();
        check("geom_final_status", status, 32'h8004_0002);
        tick(2);
        start(16'd1);
        check("geom_err_cleared", status, 32'h5004_0000);

        // cmd_stop while armed
        snap();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("arm_stop_status", status, 32'h0004_0000);
        tick(2);
        check("arm_stop_no_fstart", 32'(fs_cnt - fs0), 32'd0);

        // cmd_start and cmd_stop together in IDLE
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        tick(2);
        check("collide_busy_later", 32'(busy), 32'd0);

        // cmd_stop coincident with vsync in CAPTURE
        start(16'd0);
        vsync();
        frame();
        vid_in_vsync = 1'b1;
        cmd_stop     = 1'b1;
        tick();
        vid_in_vsync = 1'b0;
        cmd_stop     = 1'b0;
        check("stop_vs_status", status, 32'h0004_0001);
        check("stop_vs_fdone", 32'(frame_done), 32'd1);
        check("stop_vs_no_fstart", 32'(frame_start), 32'd0);
        tick(2);

        // Reset in the middle of line 2
        start(16'd0);
        vsync();
        line(W);
        vid_in_VDE = 1'b1;
        tick(4);
        snap();
        vid_rstn   = 1'b0;
        vid_in_VDE = 1'b0;
        tick();
        vid_rstn = 1'b1;
        check("rst_mid_status", status, 32'h0);
        check("rst_mid_cap_en", 32'(cap_en), 32'd0);
        tick(5);
        check("rst_mid_no_fdone", 32'(fd_cnt - fd0), 32'd0);

        // Normal capture after mid-frame reset
        snap();
        start(16'd1);
        vsync();
        frame();
        vsync();
        check("post_rst_status", status, 32'h0004_0001);
        tick(3);
        check("post_rst_cap_en_count", 32'(ce_cnt - ce0), 32'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vid_capture_ctrl.md
# vid_capture_ctrl

Frame-capture sequencer for the PixelClk video domain. It takes start/stop/frame-count commands originating in the PS register bank, then aligns capture to `vid_in_vsync` frame boundaries. It gates downstream capture with `cap_en` and checks each frame's geometry against the configured image size. A 32-bit status word is returned to the PS read-back mux.

## Interface
Parameters:
- CAM_IMAGE_WIDTH, default 1280: expected active pixels per line; must fit 12 bits.
- CAM_IMAGE_HEIGHT, default 720: expected active lines per frame; must fit 12 bits.

Ports:
- PixelClk  in  1  the only clock; all logic is on its rising edge.
- vid_rstn  in  1  reset, synchronous and active-low.
- cmd_start  in  1  one-cycle pulse that arms a capture run.
- cmd_stop  in  1  one-cycle pulse that ends the run.
- cmd_nframes  in  16  frames per run; 0 means continuous. Sampled at the accepted cmd_start.
- vid_in_vsync  in  1  active-high vertical sync.
- vid_in_VDE  in  1  active-video enable.
- cap_en  out  1  registered capture gate for the downstream writer.
- frame_start  out  1  one-cycle pulse when a captured frame begins.
- frame_done  out  1  one-cycle pulse when a captured frame ends.
- busy  out  1  high in any state other than IDLE.
- status  out  32  {err, busy, state[1:0], last_lines[11:0], frames_done[15:0]}.

## Operation
- Edge detect: registered copies vs_q and vde_q. vs_rise = vid_in_vsync & ~vs_q. vde_fall = vde_q & ~vid_in_VDE.
- State encodings: IDLE=0, ARM=1, CAPTURE=2, STOPPING=3.
- IDLE:
  - cmd_start without cmd_stop goes to ARM. This latches nframes, clears frames_done and err.
  - If cmd_start and cmd_stop arrive together, the state stays IDLE.
- ARM:
  - vs_rise goes to CAPTURE and pulses frame_start.
  - cmd_stop goes to IDLE with no frame captured.
- CAPTURE: on vs_rise the current frame ends.
  - frame_done pulses, frames_done increments (wraps at 16 bits), and last_lines is loaded from line_cnt.
  - If line_cnt differs from CAM_IMAGE_HEIGHT, err is set.
  - If nframes≠0 and the new frames_done equals nframes, the state goes to IDLE.
  - Otherwise the state stays in CAPTURE and frame_start pulses in the same cycle as frame_done.
- CAPTURE + cmd_stop (no vs_rise in that cycle): go to STOPPING. The current frame completes.
- STOPPING: on vs_rise, do the frame-end processing above, then go to IDLE. Further cmd_stop pulses are ignored.
- cmd_stop coincident with vs_rise in CAPTURE: frame-end processing runs, then the state goes directly to IDLE.
- cmd_start in any non-IDLE state is ignored.
- Counters:
  - pix_cnt: cleared at frame start and at vde_fall, otherwise +1 per cycle with VDE high.
  - line_cnt: cleared at frame start, +1 at each vde_fall.
  - Both counters are 12 bits and saturate at 4095.
- Width check: at each vde_fall in CAPTURE/STOPPING, if pix_cnt differs from CAM_IMAGE_WIDTH, err is set.
- err is sticky until the next accepted cmd_start or reset.
- Counters and checks are active only in CAPTURE and STOPPING; they are frozen in IDLE and ARM.

## Timing
- Reset: state=IDLE. cap_en, frame_start, frame_done, busy, err, last_lines, frames_done, counters, vs_q and vde_q are all 0, so status=0.
- A command takes effect on the clock edge where it is sampled. busy is high the cycle after an accepted cmd_start.
- cap_en is 1 at cycle N+1 if vid_in_VDE=1 at cycle N and the state at cycle N was CAPTURE or STOPPING. Downstream delays data by one cycle to align.
- frame_start and frame_done are registered: high the cycle after the qualifying vs_rise, for exactly 1 cycle.
- status fields update together, on the same edge as frame_done.
- Reset asserted mid-frame returns everything to reset values on the next edge; no frame_done is emitted.

## Test plan
- Bench parameters WIDTH=8, HEIGHT=4.
- Single frame: nframes=1, start, then a vsync, 4 lines × 8 VDE cycles, then a vsync.
  - Required: one frame_start, one frame_done, 32 cap_en cycles, status=0x0004_0001 after completion, busy back to 0.
- Continuous run: nframes=0, 3 good frames, then cmd_stop mid-frame 4.
  - Required: frame 4 completes; frames_done=4; back in IDLE after the 5th vsync; err=0.
- Geometry error: one line of 7 pixels in a nframes=2 run.
  - Required: err=1 (status[31]) after that line; the run still completes 2 frames; the next cmd_start clears err.
- Command collisions:
  - cmd_start+cmd_stop together in IDLE: busy stays 0.
  - cmd_stop in ARM: IDLE, frames_done=0, no frame_start.
  - cmd_stop coincident with vsync: IDLE in 1 cycle.
- Reset mid-frame: vid_rstn low for 1 cycle during line 2.
  - Required: next cycle status=0, cap_en=0, no frame_done.
  - A subsequent start/frame sequence captures normally.
